// File: rtl/csr_if.sv
// csr_if: CSR read/write port between the pipeline (master) and the CSR file (slave).
interface csr_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  modport master (output csr_raddr, csr_we, csr_waddr, csr_wdata, input csr_rdata);
  modport slave (input csr_raddr, csr_we, csr_waddr, csr_wdata, output csr_rdata);
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs, 64-bit cycle/instret counters, interrupt entry/MRET redirect and WFI sleep.
module csr_file (
  input  logic        clk,
  input  logic        rst_n,
  csr_if.slave        bus,
  input  logic        instret_valid,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        irq_allow,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        wfi,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        wfi_stall
);
  typedef enum logic {RUN, SLEEP} state_e;
  state_e      state_q;
  logic        mie_q, mpie_q, meie_q, mtie_q;
  logic [31:0] mtvec_q, mepc_q;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] mstatus_v, mie_v, mip_v, reg_v;
  logic [1:0]  pending;
  logic        take_irq, do_mret, bypass;
  logic        w300, w304, w305, w341, w_cl, w_ch, w_il, w_ih;

  function automatic logic [31:0] wmask(input logic [11:0] a);
    return a == 12'h300 ? 32'h0000_0088 :
           a == 12'h304 ? 32'h0000_0880 :
           (a == 12'h305 || a == 12'h341) ? 32'hFFFF_FFFC :
           (a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82) ? 32'hFFFF_FFFF : 32'h0;
  endfunction

  assign mstatus_v = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mie_v     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
  assign mip_v     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
  assign pending   = {ext_irq & meie_q, timer_irq & mtie_q};
  assign take_irq  = |pending & mie_q & irq_allow & (state_q == RUN);
  assign do_mret   = mret & ~take_irq;
  // rst_n gate keeps a stray mret from redirecting while held in reset
  assign redirect_valid = rst_n & (take_irq | do_mret);
  assign redirect_pc    = take_irq ? mtvec_q : mepc_q;
  assign wfi_stall      = state_q == SLEEP;

  always_comb begin
    w300 = bus.csr_we && bus.csr_waddr == 12'h300;
    w304 = bus.csr_we && bus.csr_waddr == 12'h304;
    w305 = bus.csr_we && bus.csr_waddr == 12'h305;
    w341 = bus.csr_we && bus.csr_waddr == 12'h341;
    w_cl = bus.csr_we && bus.csr_waddr == 12'hB00;
    w_ch = bus.csr_we && bus.csr_waddr == 12'hB80;
    w_il = bus.csr_we && bus.csr_waddr == 12'hB02;
    w_ih = bus.csr_we && bus.csr_waddr == 12'hB82;
    mcycle_d = (w_cl | w_ch) ? {w_ch ? bus.csr_wdata : mcycle_q[63:32], w_cl ? bus.csr_wdata : mcycle_q[31:0]}
                             : mcycle_q + 64'd1;
    minstret_d = (w_il | w_ih) ? {w_ih ? bus.csr_wdata : minstret_q[63:32], w_il ? bus.csr_wdata : minstret_q[31:0]}
                               : minstret_q + {63'd0, instret_valid};
    reg_v = bus.csr_raddr == 12'h300 ? mstatus_v :
            bus.csr_raddr == 12'h304 ? mie_v :
            bus.csr_raddr == 12'h305 ? mtvec_q :
            bus.csr_raddr == 12'h341 ? mepc_q :
            bus.csr_raddr == 12'h344 ? mip_v :
            (bus.csr_raddr == 12'hB00 || bus.csr_raddr == 12'hC00) ? mcycle_q[31:0] :
            (bus.csr_raddr == 12'hB80 || bus.csr_raddr == 12'hC80) ? mcycle_q[63:32] :
            (bus.csr_raddr == 12'hB02 || bus.csr_raddr == 12'hC02) ? minstret_q[31:0] :
            (bus.csr_raddr == 12'hB82 || bus.csr_raddr == 12'hC82) ? minstret_q[63:32] : 32'h0;
    bypass = bus.csr_we && bus.csr_waddr == bus.csr_raddr && wmask(bus.csr_raddr) != 32'h0;
    bus.csr_rdata = bypass ? (bus.csr_wdata & wmask(bus.csr_raddr)) | (bus.csr_raddr == 12'h300 ? 32'h1800 : 32'h0)
                           : reg_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= 32'h0;
      mepc_q     <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (w304) begin
        meie_q <= bus.csr_wdata[11];
        mtie_q <= bus.csr_wdata[7];
      end
      if (w305) mtvec_q <= bus.csr_wdata & 32'hFFFF_FFFC;
      if (take_irq) begin
        mepc_q <= trap_pc & 32'hFFFF_FFFC;
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else begin
        if (w341) mepc_q <= bus.csr_wdata & 32'hFFFF_FFFC;
        if (do_mret) begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end else if (w300) begin
          mie_q  <= bus.csr_wdata[3];
          mpie_q <= bus.csr_wdata[7];
        end
      end
      // wake ignores MIE: any enabled pending source ends the sleep
      state_q <= (state_q == RUN && wfi && !(|pending)) ? SLEEP :
                 (state_q == SLEEP && |pending) ? RUN : state_q;
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed scoreboard bench for csr_file.
module tb_csr_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instret_valid, ext_irq, timer_irq, irq_allow, mret, wfi;
  logic [31:0] trap_pc;
  logic        redirect_valid, wfi_stall;
  logic [31:0] redirect_pc;
  logic [31:0] sb[$];
  int          vecs = 0;
  int          errs = 0;

  csr_if bus();

  csr_file dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .instret_valid(instret_valid), .ext_irq(ext_irq), .timer_irq(timer_irq), .irq_allow(irq_allow),
    .trap_pc(trap_pc), .mret(mret), .wfi(wfi),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .wfi_stall(wfi_stall)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    vecs++;
    assert (obs === e) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb.push_back(exp);
    chk(tag, obs);
  endtask

  task automatic rdx(input string tag, input logic [11:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    bus.csr_raddr = a;
    #1;
    chk(tag, bus.csr_rdata);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1'b1;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
    @(negedge clk);
    bus.csr_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.csr_raddr = '0; bus.csr_we = 1'b0; bus.csr_waddr = '0; bus.csr_wdata = '0;
    instret_valid = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; irq_allow = 1'b0;
    trap_pc = '0; mret = 1'b1; wfi = 1'b0;
    #3;
    rdx("rst_mstatus", 12'h300, 32'h0000_1800);
    ck("rst_redirect", {31'b0, redirect_valid}, 32'h0);
    mret = 1'b0;
    ck("rst_stall", {31'b0, wfi_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(i);
      sb.push_back(i);
    end
    for (int i = 0; i < 4; i++) begin
      bus.csr_raddr = 12'hB00; #1; chk("mcycle_count", bus.csr_rdata);
      bus.csr_raddr = 12'hC00; #1; chk("cycle_shadow", bus.csr_rdata);
      @(negedge clk);
    end
    // mtvec masking, bypass, unimplemented address, read-only mip
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h305; bus.csr_wdata = 32'h0000_1003;
    rdx("mtvec_bypass", 12'h305, 32'h0000_1000);
    @(negedge clk); bus.csr_we = 1'b0;
    rdx("mtvec", 12'h305, 32'h0000_1000);
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h7C0; bus.csr_wdata = 32'hFFFF_FFFF;
    rdx("unimpl_bypass", 12'h7C0, 32'h0);
    @(negedge clk); bus.csr_we = 1'b0;
    rdx("unimpl", 12'h7C0, 32'h0);
    ext_irq = 1'b1;
    rdx("mip_live", 12'h344, 32'h0000_0800);
    wr(12'h344, 32'h0);
    rdx("mip_ro", 12'h344, 32'h0000_0800);
    ext_irq = 1'b0;
    rdx("mip_clear", 12'h344, 32'h0);
    // interrupt entry then mret
    wr(12'h304, 32'hFFFF_FFFF);
    rdx("mie", 12'h304, 32'h0000_0880);
    wr(12'h300, 32'hFFFF_FFFF);
    rdx("mstatus_wr", 12'h300, 32'h0000_1888);
    trap_pc = 32'h80; irq_allow = 1'b1; ext_irq = 1'b1;
    #1;
    ck("trap_valid", {31'b0, redirect_valid}, 32'h1);
    ck("trap_pc", redirect_pc, 32'h0000_1000);
    @(negedge clk);
    ext_irq = 1'b0; irq_allow = 1'b0;
    rdx("trap_mepc", 12'h341, 32'h80);
    rdx("trap_mstatus", 12'h300, 32'h0000_1880);
    ck("trap_pulse", {31'b0, redirect_valid}, 32'h0);
    mret = 1'b1;
    #1;
    ck("mret_valid", {31'b0, redirect_valid}, 32'h1);
    ck("mret_pc", redirect_pc, 32'h80);
    @(negedge clk);
    mret = 1'b0;
    rdx("mret_mstatus", 12'h300, 32'h0000_1888);
    // minstret carry and write precedence
    wr(12'hB02, 32'hFFFF_FFFF);
    rdx("minstret_lo", 12'hB02, 32'hFFFF_FFFF);
    instret_valid = 1'b1;
    @(negedge clk);
    instret_valid = 1'b0;
    rdx("minstret_carry_lo", 12'hB02, 32'h0);
    rdx("minstret_carry_hi", 12'hB82, 32'h1);
    rdx("instreth_shadow", 12'hC82, 32'h1);
    instret_valid = 1'b1;
    bus.csr_we = 1'b1; bus.csr_waddr = 12'hB02; bus.csr_wdata = 32'h5;
    @(negedge clk);
    bus.csr_we = 1'b0; instret_valid = 1'b0;
    rdx("minstret_wr_lo", 12'hB02, 32'h5);
    rdx("minstret_wr_hi", 12'hB82, 32'h1);
    wr(12'hC02, 32'h99);
    rdx("instret_ro", 12'hC02, 32'h5);
    // mcycle write suppresses increment, then wraps
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    rdx("mcycle_max_lo", 12'hB00, 32'hFFFF_FFFF);
    rdx("mcycle_max_hi", 12'hB80, 32'hFFFF_FFFF);
    @(negedge clk);
    rdx("mcycle_wrap_lo", 12'hB00, 32'h0);
    rdx("mcycle_wrap_hi", 12'hB80, 32'h0);
    // wfi with MIE=0, wake by timer without redirect
    wr(12'h300, 32'h0);
    wfi = 1'b1;
    @(negedge clk);
    wfi = 1'b0;
    ck("sleep", {31'b0, wfi_stall}, 32'h1);
    @(negedge clk);
    ck("sleep_hold", {31'b0, wfi_stall}, 32'h1);
    timer_irq = 1'b1;
    #1;
    ck("wake_noredir", {31'b0, redirect_valid}, 32'h0);
    @(negedge clk);
    ck("wake", {31'b0, wfi_stall}, 32'h0);
    ck("wake_noredir2", {31'b0, redirect_valid}, 32'h0);
    wfi = 1'b1;
    @(negedge clk);
    wfi = 1'b0; timer_irq = 1'b0;
    ck("wfi_noop", {31'b0, wfi_stall}, 32'h0);
    // sleep blocks the trap; taken on first RUN cycle
    wr(12'h300, 32'h8);
    wfi = 1'b1;
    @(negedge clk);
    wfi = 1'b0;
    ck("sleep_mie", {31'b0, wfi_stall}, 32'h1);
    timer_irq = 1'b1; irq_allow = 1'b1; trap_pc = 32'h100;
    #1;
    ck("sleep_block", {31'b0, redirect_valid}, 32'h0);
    @(negedge clk);
    #1;
    ck("wake_trap_valid", {31'b0, redirect_valid}, 32'h1);
    ck("wake_trap_pc", redirect_pc, 32'h0000_1000);
    ck("wake_trap_stall", {31'b0, wfi_stall}, 32'h0);
    @(negedge clk);
    timer_irq = 1'b0; irq_allow = 1'b0;
    rdx("wake_mepc", 12'h341, 32'h100);
    // trap beats mret and the software mepc write
    wr(12'h300, 32'h8);
    ext_irq = 1'b1; irq_allow = 1'b1; mret = 1'b1; trap_pc = 32'h200;
    bus.csr_we = 1'b1; bus.csr_waddr = 12'h341; bus.csr_wdata = 32'h44;
    #1;
    ck("race_valid", {31'b0, redirect_valid}, 32'h1);
    ck("race_pc", redirect_pc, 32'h0000_1000);
    @(negedge clk);
    ext_irq = 1'b0; irq_allow = 1'b0; mret = 1'b0; bus.csr_we = 1'b0;
    rdx("race_mepc", 12'h341, 32'h200);
    rdx("race_mstatus", 12'h300, 32'h0000_1880);
    // reset while sleeping
    wfi = 1'b1;
    @(negedge clk);
    wfi = 1'b0;
    ck("sleep_pre_rst", {31'b0, wfi_stall}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    ck("rst_sleep", {31'b0, wfi_stall}, 32'h0);
    rdx("rst_mtvec", 12'h305, 32'h0);
    rdx("rst_mepc", 12'h341, 32'h0);
    rdx("rst_mie", 12'h304, 32'h0);
    rdx("rst_mcycle", 12'hB00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: csr_raddr  in  12  read address from EX; csr_rdata  out  32  read value feeding the ALU CSR operand.
REQ-004 SHALL have ports: csr_we  in  1; csr_waddr  in  12; csr_wdata  in  32 -- ALU CSR result, write-back stage.
REQ-005 SHALL have ports: instret_valid  in  1  one instruction retired this cycle.
REQ-006 SHALL have ports: ext_irq  in  1 (MEIP source); timer_irq  in  1 (MTIP source); irq_allow  in  1  pipeline at safe trap point.
REQ-007 SHALL have ports: trap_pc  in  32  PC saved on trap; mret  in  1  MRET in WB; wfi  in  1  WFI in WB.
REQ-008 SHALL have ports: redirect_valid  out  1; redirect_pc  out  32; wfi_stall  out  1.

Function
REQ-009 SHALL implement mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11; all other bits read 0.
REQ-010 SHALL implement mie 0x304: MEIE bit 11, MTIE bit 7 writable; other bits read 0.
REQ-011 SHALL implement mtvec 0x305 (direct mode, bits 1:0 read 0) and mepc 0x341 (bits 1:0 read 0).
REQ-012 SHALL implement mip 0x344 read-only: bit 11 = ext_irq, bit 7 = timer_irq, sampled live.
REQ-013 SHALL implement 64-bit mcycle (0xB00 low / 0xB80 high) and minstret (0xB02 / 0xB82), writable per 32-bit half.
REQ-014 SHALL expose read-only shadows cycle 0xC00/0xC80 and instret 0xC02/0xC82.
REQ-015 SHALL return 0 for unimplemented addresses; writes to them and to read-only CSRs have no effect.
REQ-016 csr_rdata SHALL be combinational; when csr_we and csr_waddr==csr_raddr on a writable CSR, it SHALL return csr_wdata masked to implemented bits (bypass).
REQ-017 mcycle SHALL increment by 1 every cycle; minstret SHALL increment when instret_valid; both wrap 2^64-1 -> 0.
REQ-018 A software write to a counter half SHALL replace that half and suppress the increment that cycle; carry into the other half also suppressed.
REQ-019 pending = {mip[11]&mie[11], mip[7]&mie[7]}; take_irq = |pending & mstatus.MIE & irq_allow & state==RUN-or-wake.
REQ-020 On take_irq: mepc<=trap_pc, MPIE<=MIE, MIE<=0, redirect_valid=1 with redirect_pc=mtvec in the same cycle (combinational, one-cycle pulse).
REQ-021 On mret without take_irq: MIE<=MPIE, MPIE<=1, redirect_valid=1, redirect_pc=mepc.
REQ-022 take_irq and mret in the same cycle: trap wins, mret ignored.
REQ-023 Trap/mret updates to mstatus/mepc SHALL override a software write to the same CSR in the same cycle; other CSR writes proceed.
REQ-024 State machine RUN/SLEEP: RUN --wfi--> SLEEP; SLEEP --|pending (MIE ignored)--> RUN; wfi_stall=1 exactly while state==SLEEP.
REQ-025 wfi with |pending already true SHALL leave state in RUN (no-op).
REQ-026 In SLEEP, take_irq is blocked; after wake, an interrupt with MIE=1 is taken on the first RUN cycle with irq_allow.

Reset
REQ-027 On rst_n low, asynchronously: mstatus.MIE=0, MPIE=0, mie=0, mtvec=0, mepc=0, counters=0, state=RUN.
REQ-028 Under reset, redirect_valid=0, wfi_stall=0; csr_rdata reflects reset contents.
REQ-029 Reset asserted in SLEEP SHALL return to RUN with wfi_stall=0 immediately.

Verification
REQ-030 Reset release, read 0xB00 on cycles 1..4 -> 0,1,2,3; read 0xC00 matches.
REQ-031 Write mtvec=0x0000_1003, read -> 0x0000_1000; write 0x7C0 -> no effect, read 0.
REQ-032 MIE=1, MEIE=1, ext_irq=1, irq_allow=1, trap_pc=0x80 -> redirect_pc=mtvec, next mepc=0x80, MIE=0, MPIE=1; then mret -> redirect_pc=0x80, MIE=1.
REQ-033 minstret=0x0000_0000_FFFF_FFFF, instret_valid=1 -> 0x0000_0001_0000_0000; same cycle write 0xB02=5 -> low=5, high unchanged.
REQ-034 wfi with MIE=0, MTIE=1 -> wfi_stall=1; timer_irq=1 -> wfi_stall=0 next cycle, no redirect.
REQ-035 take_irq and mret same cycle, plus csr_we to mepc=0x44 -> redirect_pc=mtvec, mepc=trap_pc.
